// File: rtl/nn_pkg.sv
// Shared neural-network datapath types and Q8.8 constants.
// Used by the neuron MAC and the layer-level scaling logic.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    localparam logic [DATA_W-1:0] Q_ONE  = 16'h0100;
    localparam logic [DATA_W-1:0] Q_HALF = 16'h0080;
    localparam logic [DATA_W-1:0] Q_MAX  = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN  = 16'h8000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_OUT
    } state_t;

endpackage

// File: rtl/q_round_sat.sv
// Round-half-up and signed clamp from a wide fixed-point accumulator
// down to a DATA_W result with FRAC_W fractional bits.
module q_round_sat #(
    parameter int ACC_W  = 40,
    parameter int FRAC_W = 8,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] sum_o,
    output logic                     sat_o
);

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] rnd;

    always_comb begin
        biased = acc_i + HALF;
        rnd    = biased >>> FRAC_W;
        sum_o  = rnd[DATA_W-1:0];
        sat_o  = 1'b0;
        if (rnd > MAX) begin
            sum_o = MAX[DATA_W-1:0];
            sat_o = 1'b1;
        end else if (rnd < MIN) begin
            sum_o = MIN[DATA_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron streaming multiply-accumulate with bias, feeding the
// sigmoid LUT through a valid/ready output port.
module neuron_mac #(
    parameter int N_INPUTS = 16,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_sat,
    output logic              busy
);

    import nn_pkg::*;

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N_INPUTS);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      p_vld_q, p_vld_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         out_sum_q, out_sum_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic                      beat;
    logic signed [PROD_W-1:0]  prod_in;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic [DATA_W-1:0]         rs_sum;
    logic                      rs_sat;

    assign in_ready = (state_q == S_IDLE)
                    | ((state_q == S_ACCUM) & (cnt_q < CNT_N));
    assign beat     = in_valid & in_ready;
    assign prod_in  = $signed(in_x) * $signed(in_w);
    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}},
                       bias, {FRAC_W{1'b0}}};

    q_round_sat #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W),
        .DATA_W (DATA_W)
    ) u_round (
        .acc_i (acc_q),
        .sum_o (rs_sum),
        .sat_o (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        p_vld_d     = 1'b0;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        if (beat) begin
            prod_d  = prod_in;
            p_vld_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end

        // A first beat seeds the accumulator; no product is pending then.
        if (beat && state_q == S_IDLE) begin
            acc_d = bias_ext;
        end else if (p_vld_q) begin
            acc_d = acc_q + prod_ext;
        end

        unique case (state_q)
            S_IDLE: begin
                if (beat) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (cnt_q == CNT_N && !p_vld_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                out_sum_d   = rs_sum;
                out_sat_d   = rs_sat;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            p_vld_q     <= p_vld_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule
